lock_sequencer: RTL and testbench

- Top-level control FSM for the digital lock box.
- Collects three 3-bit code digits from switches, one per debounced enter pulse, and holds them in the entered-password registers feeding comparison_checker.
- Samples the checker's match result to unlock, and counts failed attempts into a timed lockout.
- While unlocked, sequences a new three-digit password into the set-password registers; the new password commits atomically.

---
 rtl/lock_sequencer.sv | 150 +++++++++++++++
 tb/tb_lock_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// Digital lock box control FSM: collects three code digits, evaluates the
// checker's match result, manages the lockout timer and password changes.
module lock_sequencer #(
   parameter int unsigned MAX_FAILS      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 100000000,
   parameter logic [8:0]  RESET_CODE     = 9'o000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [2:0] code_in,
   input  logic       enter,
   input  logic       set_req,
   input  logic       lock_req,
   input  logic       match,
   output logic [2:0] set_pass1,
   output logic [2:0] set_pass2,
   output logic [2:0] set_pass3,
   output logic [2:0] en_pass1,
   output logic [2:0] en_pass2,
   output logic [2:0] en_pass3,
   output logic       unlocked,
   output logic       lockout,
   output logic [1:0] digit_idx,
   output logic [2:0] fail_cnt
);

   localparam int unsigned TW = $clog2(LOCKOUT_CYCLES + 1);

   typedef enum logic [3:0] {
      ENT1, ENT2, ENT3, CHECK, OPEN, SET1, SET2, SET3, LOCKOUT
   } state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] timer;
   logic [2:0]    stage1, stage2;
   logic [3:0]    fail_inc;
   logic          fail_last;

   // One more failure would reach the limit; the 4-bit sum avoids wrapping.
   always_comb begin
      fail_inc  = {1'b0, fail_cnt} + 4'd1;
      fail_last = (fail_inc >= 4'(MAX_FAILS));
   end

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= ENT1;
      else     state <= state_nxt;
   end

   // Next-state logic; lock_req outranks set_req and enter.
   always_comb begin
      state_nxt = state;
      case (state)
         ENT1:    if (enter) state_nxt = ENT2;
         ENT2:    if (enter) state_nxt = ENT3;
         ENT3:    if (enter) state_nxt = CHECK;
         CHECK: begin
            if (match)          state_nxt = OPEN;
            else if (fail_last) state_nxt = LOCKOUT;
            else                state_nxt = ENT1;
         end
         OPEN: begin
            if (lock_req)     state_nxt = ENT1;
            else if (set_req) state_nxt = SET1;
         end
         SET1: begin
            if (lock_req)   state_nxt = ENT1;
            else if (enter) state_nxt = SET2;
         end
         SET2: begin
            if (lock_req)   state_nxt = ENT1;
            else if (enter) state_nxt = SET3;
         end
         SET3: begin
            if (lock_req)   state_nxt = ENT1;
            else if (enter) state_nxt = OPEN;
         end
         LOCKOUT: if (timer == '0) state_nxt = ENT1;
         default: state_nxt = ENT1;
      endcase
   end

   // Datapath: digit capture, password staging/commit, failure count, timer.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         set_pass1 <= RESET_CODE[8:6];
         set_pass2 <= RESET_CODE[5:3];
         set_pass3 <= RESET_CODE[2:0];
         en_pass1  <= '0;
         en_pass2  <= '0;
         en_pass3  <= '0;
         stage1    <= '0;
         stage2    <= '0;
         fail_cnt  <= '0;
         timer     <= '0;
      end else begin
         case (state)
            ENT1: if (enter) en_pass1 <= code_in;
            ENT2: if (enter) en_pass2 <= code_in;
            ENT3: if (enter) en_pass3 <= code_in;
            CHECK: begin
               en_pass1 <= '0;
               en_pass2 <= '0;
               en_pass3 <= '0;
               if (match) begin
                  fail_cnt <= '0;
               end else if (fail_last) begin
                  fail_cnt <= 3'(MAX_FAILS);
                  timer    <= TW'(LOCKOUT_CYCLES - 1);
               end else begin
                  fail_cnt <= fail_inc[2:0];
               end
            end
            SET1: if (!lock_req && enter) stage1 <= code_in;
            SET2: if (!lock_req && enter) stage2 <= code_in;
            // All three digits commit on the same edge, or not at all.
            SET3: if (!lock_req && enter) begin
               set_pass1 <= stage1;
               set_pass2 <= stage2;
               set_pass3 <= code_in;
            end
            LOCKOUT: begin
               if (timer == '0) fail_cnt <= '0;
               else             timer    <= timer - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Moore output decode from state only.
   always_comb begin
      unlocked  = 1'b0;
      lockout   = 1'b0;
      digit_idx = 2'd3;
      case (state)
         ENT1:    digit_idx = 2'd0;
         ENT2:    digit_idx = 2'd1;
         ENT3:    digit_idx = 2'd2;
         OPEN:    unlocked  = 1'b1;
         SET1: begin unlocked = 1'b1; digit_idx = 2'd0; end
         SET2: begin unlocked = 1'b1; digit_idx = 2'd1; end
         SET3: begin unlocked = 1'b1; digit_idx = 2'd2; end
         LOCKOUT: lockout   = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with a behavioural comparison checker.
module tb_lock_sequencer;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [2:0] code_in = '0;
   logic       enter = 1'b0;
   logic       set_req = 1'b0;
   logic       lock_req = 1'b0;
   logic       match;
   logic [2:0] set_pass1, set_pass2, set_pass3;
   logic [2:0] en_pass1, en_pass2, en_pass3;
   logic       unlocked, lockout;
   logic [1:0] digit_idx;
   logic [2:0] fail_cnt;

   int n_cmp = 0;
   int n_err = 0;

   lock_sequencer #(
      .MAX_FAILS      (3),
      .LOCKOUT_CYCLES (8),
      .RESET_CODE     (9'o000)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .code_in   (code_in),
      .enter     (enter),
      .set_req   (set_req),
      .lock_req  (lock_req),
      .match     (match),
      .set_pass1 (set_pass1),
      .set_pass2 (set_pass2),
      .set_pass3 (set_pass3),
      .en_pass1  (en_pass1),
      .en_pass2  (en_pass2),
      .en_pass3  (en_pass3),
      .unlocked  (unlocked),
      .lockout   (lockout),
      .digit_idx (digit_idx),
      .fail_cnt  (fail_cnt)
   );

   // External comparison checker.
   assign match = ({en_pass1, en_pass2, en_pass3} == {set_pass1, set_pass2, set_pass3});

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_enter(input logic [2:0] d);
      code_in = d;
      enter   = 1'b1;
      tick();
      enter   = 1'b0;
   endtask

   task automatic send_code(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
      send_enter(a);
      send_enter(b);
      send_enter(c);
   endtask

   task automatic pulse_lock();
      lock_req = 1'b1;
      tick();
      lock_req = 1'b0;
   endtask

   task automatic pulse_set();
      set_req = 1'b1;
      tick();
      set_req = 1'b0;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_unlocked", 32'(unlocked), 0);
      chk("rst_lockout", 32'(lockout), 0);
      chk("rst_idx", 32'(digit_idx), 0);
      chk("rst_fail", 32'(fail_cnt), 0);
      chk("rst_setpass", {23'd0, set_pass1, set_pass2, set_pass3}, 0);
      chk("rst_enpass", {23'd0, en_pass1, en_pass2, en_pass3}, 0);
      RST = 1'b0;
      tick();

      // Power-on code 0,0,0 unlocks two edges after third enter
      send_code(3'd0, 3'd0, 3'd0);
      chk("chk_idx", 32'(digit_idx), 3);
      chk("chk_unlocked", 32'(unlocked), 0);
      tick();
      chk("open_unlocked", 32'(unlocked), 1);
      chk("open_fail", 32'(fail_cnt), 0);
      chk("open_enpass", {23'd0, en_pass1, en_pass2, en_pass3}, 0);

      // Change password to 5,2,7
      pulse_set();
      chk("set1_idx", 32'(digit_idx), 0);
      chk("set1_unlocked", 32'(unlocked), 1);
      send_enter(3'd5);
      send_enter(3'd2);
      chk("set3_idx", 32'(digit_idx), 2);
      chk("set_nocommit", {23'd0, set_pass1, set_pass2, set_pass3}, 0);
      send_enter(3'd7);
      chk("set_commit", {23'd0, set_pass1, set_pass2, set_pass3}, 9'o527);
      chk("set_back_open", 32'(digit_idx), 3);

      // Relock, then new code unlocks
      pulse_lock();
      chk("relock_unlocked", 32'(unlocked), 0);
      chk("relock_idx", 32'(digit_idx), 0);
      send_code(3'd5, 3'd2, 3'd7);
      chk("en_capture", {23'd0, en_pass1, en_pass2, en_pass3}, 9'o527);
      tick();
      chk("newcode_unlocked", 32'(unlocked), 1);

      // Old code now fails
      pulse_lock();
      send_code(3'd0, 3'd0, 3'd0);
      tick();
      chk("wrong_fail1", 32'(fail_cnt), 1);
      chk("wrong_idx", 32'(digit_idx), 0);
      chk("wrong_unlocked", 32'(unlocked), 0);
      chk("wrong_enclr", {23'd0, en_pass1, en_pass2, en_pass3}, 0);

      // Abort change after two digits
      send_code(3'd5, 3'd2, 3'd7);
      tick();
      chk("reopen_fail", 32'(fail_cnt), 0);
      pulse_set();
      send_enter(3'd3);
      send_enter(3'd3);
      pulse_lock();
      chk("abort_setpass", {23'd0, set_pass1, set_pass2, set_pass3}, 9'o527);
      chk("abort_idx", 32'(digit_idx), 0);
      chk("abort_unlocked", 32'(unlocked), 0);

      // lock_req and enter together in SET3: no commit
      send_code(3'd5, 3'd2, 3'd7);
      tick();
      pulse_set();
      send_enter(3'd1);
      send_enter(3'd1);
      code_in  = 3'd1;
      enter    = 1'b1;
      lock_req = 1'b1;
      tick();
      enter    = 1'b0;
      lock_req = 1'b0;
      chk("lockwin_setpass", {23'd0, set_pass1, set_pass2, set_pass3}, 9'o527);
      chk("lockwin_idx", 32'(digit_idx), 0);

      // set_req and lock_req in the same OPEN cycle
      send_code(3'd5, 3'd2, 3'd7);
      tick();
      set_req  = 1'b1;
      lock_req = 1'b1;
      tick();
      set_req  = 1'b0;
      lock_req = 1'b0;
      chk("prio_idx", 32'(digit_idx), 0);
      chk("prio_unlocked", 32'(unlocked), 0);

      // Two failures then success clears the count
      send_code(3'd0, 3'd0, 3'd0);
      tick();
      send_code(3'd0, 3'd0, 3'd0);
      tick();
      chk("two_fail", 32'(fail_cnt), 2);
      chk("two_lockout", 32'(lockout), 0);
      send_code(3'd5, 3'd2, 3'd7);
      tick();
      chk("clr_fail", 32'(fail_cnt), 0);
      chk("clr_unlocked", 32'(unlocked), 1);
      pulse_lock();

      // Third consecutive failure: 8-cycle lockout, inputs ignored
      send_code(3'd0, 3'd0, 3'd0);
      tick();
      send_code(3'd0, 3'd0, 3'd0);
      tick();
      send_code(3'd0, 3'd0, 3'd0);
      tick();
      chk("lo_enter", 32'(lockout), 1);
      chk("lo_fail", 32'(fail_cnt), 3);
      chk("lo_idx", 32'(digit_idx), 3);
      code_in  = 3'd5;
      enter    = 1'b1;
      set_req  = 1'b1;
      lock_req = 1'b1;
      for (int i = 1; i < 8; i++) begin
         tick();
         chk($sformatf("lo_hold%0d", i), 32'(lockout), 1);
      end
      enter    = 1'b0;
      set_req  = 1'b0;
      lock_req = 1'b0;
      tick();
      chk("lo_exit", 32'(lockout), 0);
      chk("lo_exit_fail", 32'(fail_cnt), 0);
      chk("lo_exit_idx", 32'(digit_idx), 0);
      send_code(3'd5, 3'd2, 3'd7);
      tick();
      chk("lo_after_unlock", 32'(unlocked), 1);

      // Asynchronous reset mid-SET2
      pulse_set();
      send_enter(3'd4);
      chk("set2_idx", 32'(digit_idx), 1);
      RST = 1'b1;
      #1;
      chk("rs2_unlocked", 32'(unlocked), 0);
      chk("rs2_idx", 32'(digit_idx), 0);
      chk("rs2_setpass", {23'd0, set_pass1, set_pass2, set_pass3}, 0);
      RST = 1'b0;
      tick();
      send_code(3'd0, 3'd0, 3'd0);
      tick();
      chk("rs2_unlock", 32'(unlocked), 1);

      // Asynchronous reset mid-LOCKOUT
      pulse_lock();
      send_code(3'd1, 3'd1, 3'd1);
      tick();
      send_code(3'd1, 3'd1, 3'd1);
      tick();
      send_code(3'd1, 3'd1, 3'd1);
      tick();
      tick();
      chk("rsl_pre", 32'(lockout), 1);
      RST = 1'b1;
      #1;
      chk("rsl_lockout", 32'(lockout), 0);
      chk("rsl_fail", 32'(fail_cnt), 0);
      chk("rsl_idx", 32'(digit_idx), 0);
      RST = 1'b0;
      tick();
      send_code(3'd0, 3'd0, 3'd0);
      tick();
      chk("rsl_unlock", 32'(unlocked), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
